// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the FSM encoding and BCD digit limits.
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade counter of the stopwatch chain.
// Carry is combinational so the whole chain advances on a single edge.
module bcd_digit_cell
    import stopwatch_pkg::*;
(
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Clear_In,
    input  logic             Inc_In,
    output logic [BCD_W-1:0] Digit_Out,
    output logic             Carry_Out
);

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            Digit_Out <= '0;
        end else if (Clear_In) begin
            Digit_Out <= '0;
        end else if (Inc_In) begin
            // >= keeps any illegal code from escaping past 9
            if (Digit_Out >= BCD_MAX) begin
                Digit_Out <= '0;
            end else begin
                Digit_Out <= Digit_Out + 4'd1;
            end
        end
    end

    assign Carry_Out = Inc_In && (Digit_Out == BCD_MAX);

endmodule

// File: rtl/stopwatch_controller.sv
// Start/stop/lap/clear stopwatch: FSM, prescaler, lap register,
// overflow flag and a chain of BCD digit cells.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Start_Stop_In,
    input  logic                  Lap_In,
    input  logic                  Clear_In,
    output logic [4*DIGITS-1:0]   Display_Out,
    output logic                  Running_Out,
    output logic                  Lap_Active_Out,
    output logic                  Overflow_Out
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]       pre;
    logic [4*DIGITS-1:0] live;
    logic [4*DIGITS-1:0] lap_q;
    logic [DIGITS:0]     inc;
    logic                counting;
    logic                tick;
    logic                lap_cap;
    logic                clr_cnt;
    logic                clr_ovf;
    logic                ovf;

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (pre == PRE_LAST);

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start_Stop outranks Lap; Clear outranks Start_Stop in PAUSE
    always_comb begin
        state_nxt = state;
        lap_cap   = 1'b0;
        clr_cnt   = 1'b0;
        clr_ovf   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Clear_In) begin
                    clr_ovf = 1'b1;
                end
                if (Start_Stop_In) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Start_Stop_In) begin
                    state_nxt = ST_PAUSE;
                end else if (Lap_In) begin
                    lap_cap   = 1'b1;
                    state_nxt = ST_LAP;
                end
            end
            ST_LAP: begin
                if (Start_Stop_In) begin
                    state_nxt = ST_PAUSE;
                end else if (Lap_In) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (Clear_In) begin
                    clr_cnt   = 1'b1;
                    clr_ovf   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (Start_Stop_In) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Held in PAUSE so a resume keeps the partial tick
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            pre <= '0;
        end else if (clr_cnt) begin
            pre <= '0;
        end else if (counting) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    assign inc[0] = tick;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .Clk_In    (Clk_In),
            .Reset_In  (Reset_In),
            .Clear_In  (clr_cnt),
            .Inc_In    (inc[k]),
            .Digit_Out (live[4*k +: 4]),
            .Carry_Out (inc[k+1])
        );
    end

    // Capture uses the pre-increment value registered before this edge
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            lap_q <= '0;
        end else if (lap_cap) begin
            lap_q <= live;
        end
    end

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            ovf <= 1'b0;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end else if (inc[DIGITS]) begin
            ovf <= 1'b1;
        end
    end

    assign Display_Out    = (state == ST_LAP) ? lap_q : live;
    assign Running_Out    = counting;
    assign Lap_Active_Out = (state == ST_LAP);
    assign Overflow_Out   = ovf;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed and randomized bench for stopwatch_controller against
// a decimal-arithmetic reference model (DIGITS=2, TICK_DIV=3).
module tb_stopwatch_controller;

    localparam int DIGITS = 2;
    localparam int TD     = 3;
    localparam int WRAP   = 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss  = 1'b0;
    logic       lp  = 1'b0;
    logic       cl  = 1'b0;
    logic [7:0] disp;
    logic       running;
    logic       lap_act;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    int m_mode;
    int m_cnt;
    int m_pre;
    int m_lap;
    bit m_ovf;

    stopwatch_controller #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TD)
    ) dut (
        .Clk_In         (clk),
        .Reset_In       (rst),
        .Start_Stop_In  (ss),
        .Lap_In         (lp),
        .Clear_In       (cl),
        .Display_Out    (disp),
        .Running_Out    (running),
        .Lap_Active_Out (lap_act),
        .Overflow_Out   (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_pre  = 0;
        m_lap  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(bit s, bit l, bit c);
        int old;
        old = m_cnt;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                m_cnt = (m_cnt + 1) % WRAP;
                if (m_cnt == 0) m_ovf = 1'b1;
            end else begin
                m_pre++;
            end
        end
        case (m_mode)
            M_IDLE: begin
                if (c) m_ovf = 1'b0;
                if (s) m_mode = M_RUN;
            end
            M_RUN: begin
                if (s) m_mode = M_PAUSE;
                else if (l) begin
                    m_lap  = old;
                    m_mode = M_LAP;
                end
            end
            M_LAP: begin
                if (s) m_mode = M_PAUSE;
                else if (l) m_mode = M_RUN;
            end
            default: begin
                if (c) begin
                    m_cnt  = 0;
                    m_pre  = 0;
                    m_ovf  = 1'b0;
                    m_mode = M_IDLE;
                end else if (s) m_mode = M_RUN;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [7:0] e_disp;
        e_disp = (m_mode == M_LAP) ? to_bcd(m_lap) : to_bcd(m_cnt);
        check("disp", 32'(disp), 32'(e_disp));
        check("running", 32'(running),
              32'(m_mode == M_RUN || m_mode == M_LAP));
        check("lap_act", 32'(lap_act), 32'(m_mode == M_LAP));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // Inputs change at posedge; the DUT samples them at the next negedge
    task automatic cycle(bit s, bit l, bit c);
        ss = s;
        lp = l;
        cl = c;
        @(negedge clk);
        model_step(s, l, c);
        @(posedge clk);
        ss = 1'b0;
        lp = 1'b0;
        cl = 1'b0;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("arst_disp", 32'(disp), 32'h0);
        check("arst_run", 32'(running), 32'h0);
        check("arst_lap", 32'(lap_act), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);
        model_reset();
        @(posedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(posedge clk);
        compare_all();
        rst = 1'b0;

        cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        check("pre_tick", 32'(disp), 32'h00);
        cycle(1'b0, 1'b0, 1'b0);
        check("edge3", 32'(disp), 32'h01);
        repeat (24) cycle(1'b0, 1'b0, 1'b0);
        check("edge27", 32'(disp), 32'h09);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("edge30", 32'(disp), 32'h10);

        repeat (267) cycle(1'b0, 1'b0, 1'b0);
        check("at99", 32'(disp), 32'h99);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("wrap_disp", 32'(disp), 32'h00);
        check("wrap_ovf", 32'(ovf), 32'h1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(ovf), 32'h0);
        check("clr_idle", 32'(running), 32'h0);
        check("clr_disp", 32'(disp), 32'h00);

        cycle(1'b1, 1'b0, 1'b0);
        repeat (21) cycle(1'b0, 1'b0, 1'b0);
        check("live07", 32'(disp), 32'h07);
        cycle(1'b0, 1'b1, 1'b0);
        check("lap_hold", 32'(disp), 32'h07);
        check("lap_flag", 32'(lap_act), 32'h1);
        repeat (14) cycle(1'b0, 1'b0, 1'b0);
        check("lap_frozen", 32'(disp), 32'h07);
        cycle(1'b0, 1'b1, 1'b0);
        check("lap_release", 32'(disp), 32'h12);
        check("lap_off", 32'(lap_act), 32'h0);

        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        check("pause_hold", 32'(disp), 32'h13);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("resume_1", 32'(disp), 32'h13);
        cycle(1'b0, 1'b0, 1'b0);
        check("resume_2", 32'(disp), 32'h14);

        cycle(1'b0, 1'b0, 1'b1);
        check("run_clr_ign", 32'(running), 32'h1);
        cycle(1'b1, 1'b1, 1'b0);
        check("ss_beats_lap", 32'(lap_act), 32'h0);
        check("ss_pause", 32'(running), 32'h0);

        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400 && m_cnt != 45; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("reach45", 32'(disp), 32'h45);
        async_reset();
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        check("post_rst", 32'(disp), 32'h00);

        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit l;
            bit c;
            s = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 9) == 0);
            c = ((i / 500) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                     : ($urandom_range(0, 199) == 0);
            cycle(s, l, c);
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for a cascade of decade (BCD) digit counters, forming a start/stop/lap/clear stopwatch. It divides the system clock into count ticks with a prescaler and drives a chain of BCD digits with ripple-free carry enables. A four-state FSM gates counting and freezes the displayed value for lap readings. It sits between debounced, synchronised button pulses and a display driver.

## Interface
- DIGITS, 4: number of cascaded BCD digits; must be 1 or more.
- TICK_DIV, 10: Clk_In cycles per count tick; must be 1 or more.
- Clk_In  input  1  system clock; all registers update on its falling edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Start_Stop_In  input  1  synchronous pulse; each sampled-high cycle is one toggle request.
- Lap_In  input  1  synchronous pulse; toggles lap freeze.
- Clear_In  input  1  synchronous pulse; zeroes the count when not counting.
- Display_Out  output  4*DIGITS  BCD value; digit k is at bits [4k+3:4k], digit 0 is least significant.
- Running_Out  output  1  high in RUN and LAP.
- Lap_Active_Out  output  1  high in LAP.
- Overflow_Out  output  1  sticky wrap flag.

## Operation
- States are IDLE, RUN, PAUSE and LAP. Reset enters IDLE.
- In IDLE:
  - Start_Stop moves to RUN.
  - Clear clears Overflow_Out and stays in IDLE.
  - Lap is ignored.
- In RUN:
  - Start_Stop moves to PAUSE.
  - Lap captures the live count into the lap register and moves to LAP.
  - Clear is ignored.
- In LAP:
  - Start_Stop moves to PAUSE and releases the display.
  - Lap moves to RUN and releases the display.
  - Clear is ignored.
- In PAUSE:
  - Clear zeroes all digits, the prescaler and Overflow_Out, then moves to IDLE.
  - Start_Stop moves to RUN.
  - Lap is ignored.
- Simultaneous requests:
  - In PAUSE, Clear beats Start_Stop.
  - In RUN and LAP, Start_Stop beats Lap. The lap register is not captured in that case.
- Prescaler:
  - Counts 0 to TICK_DIV-1 on every edge in RUN or LAP. A tick fires on the edge where it equals TICK_DIV-1, and the prescaler then returns to 0.
  - Holds its value in PAUSE, so a resume keeps the fractional tick.
  - Is 0 in IDLE.
- Digits:
  - Digit 0 increments on a tick.
  - Digit k increments on a tick when digits 0 to k-1 are all 9.
  - A digit equal to 9 that increments goes to 0. No digit ever holds a value above 9.
- Wrap: a tick while all digits are 9 gives all zeros and sets Overflow_Out. The flag stays set until Clear in IDLE/PAUSE or reset. Counting continues.
- Display_Out shows the lap register in LAP and the live count otherwise.
- Lap capture samples the live count as it was before that edge's increment.

## Timing
- Reset values: every output is 0, all digits are 0, the prescaler and lap register are 0, the state is IDLE. Reset acts immediately, with no clock edge needed.
- If a Start_Stop pulse is sampled at edge n from IDLE, then RUN holds from edge n and Running_Out is high after edge n.
- The first digit-0 increment happens at edge n+TICK_DIV.
- With TICK_DIV=1, the count increments on every edge in RUN or LAP, starting at edge n+1.
- Outputs are registered or decoded from registers only, with no combinational path from the inputs. State changes are visible one edge after the request is sampled.
- Inputs are assumed to be debounced and synchronised. A level held high acts as a request on every cycle.

## Structure
- Package stopwatch_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP;
  - BCD_MAX = 4'd9;
  - BCD width = 4.
- Sub-module bcd_digit_cell is instantiated DIGITS times in a generate loop. Its ports are:
  - Clk_In, Reset_In;
  - Clear_In (synchronous zero);
  - Inc_In;
  - Digit_Out[3:0];
  - Carry_Out = Inc_In AND (Digit_Out == 9), combinational, feeding Inc_In of the next cell.
- The controller contains the FSM, the prescaler, the lap register, the overflow flag and the display mux.

## Test plan
All scenarios use DIGITS=2 and TICK_DIV=3.
- Reset, then Start_Stop at edge 0: Display_Out goes to 8'h01 at edge 3, 8'h09 at edge 27, 8'h10 at edge 30.
- Run to 8'h99, then one more tick: Display_Out=8'h00 and Overflow_Out=1. Stop, then Clear: Overflow_Out=0, state IDLE, display 8'h00.
- Lap while live count is 8'h07: Display_Out holds 8'h07 and Lap_Active_Out=1 while the live count advances. A second Lap at live 8'h12 shows 8'h12 immediately.
- Stop with the prescaler at 1, wait 20 cycles: display unchanged. Resume: the next increment comes 2 edges later.
- Clear during RUN: ignored. Start_Stop and Lap in the same cycle during RUN: state PAUSE, Lap_Active_Out=0, lap register not captured.
- Assert Reset_In asynchronously mid-RUN at count 8'h45: all outputs are 0 before the next clock edge, and counting resumes only after a new Start_Stop.
